serial_cmd_engine: RTL and testbench



---
 rtl/serial_cmd_engine_if.sv | 14 +
 rtl/serial_cmd_engine.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_serial_cmd_engine.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_cmd_engine_if.sv
// UART-side byte handshake of the serial command engine.
// The master drives received bytes and transmitter status; the slave (engine) drives send strobes.
interface serial_cmd_engine_if;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;

   modport master (output rx_ready, output rx_data, output tx_busy,
                   input tx_start, input tx_data);
   modport slave  (input rx_ready, input rx_data, input tx_busy,
                   output tx_start, output tx_data);
endinterface

// File: rtl/serial_cmd_engine.sv
// Host command engine: decodes UART opcodes, owns the config bank, snapshots histograms,
// sequences PLL phase steps and clkswitch pulses, and counts protocol errors.
module serial_cmd_engine #(
   parameter int unsigned NCH        = 4,
   parameter int unsigned HW         = 32,
   parameter int unsigned NREG       = 8,
   parameter int unsigned FW_VERSION = 10,
   parameter int unsigned SCAN_HALF  = 16,
   parameter int unsigned TIMEOUT    = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_cmd_engine_if.slave    uart,
   input  logic [NCH*HW-1:0]     hist,
   output logic                  hist_reset,
   output logic [NREG*8-1:0]     cfg,
   output logic [NREG-1:0]       cfg_wr,
   output logic [2:0]            phase_cnt_sel,
   output logic                  phase_updown,
   output logic                  phase_step,
   output logic                  scanclk,
   output logic                  clkswitch,
   output logic                  busy,
   output logic [7:0]            err_count
);

   localparam int unsigned BufW   = NCH * HW;
   localparam int unsigned NBytes = BufW / 8;
   localparam int unsigned LenW   = $clog2(NBytes + 1);
   localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);
   localparam int unsigned HcW    = $clog2(SCAN_HALF);
   localparam int unsigned AW     = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [2:0] {
      StIdle, StArgs, StExec, StTxLoad, StTxWait, StClksw, StPstep
   } state_e;

   function automatic logic [1:0] num_args(input logic [7:0] op);
      case (op)
         8'h01, 8'h05: return 2'd2;
         8'h02:        return 2'd1;
         default:      return 2'd0;
      endcase
   endfunction

   state_e              state_q, state_d;
   logic [7:0]          opcode_q, opcode_d;
   logic [7:0]          arg0_q, arg0_d, arg1_q, arg1_d;
   logic [1:0]          arg_cnt_q, arg_cnt_d;
   logic [TmoW-1:0]     tmo_q, tmo_d;
   logic [7:0]          err_q, err_d;
   logic [7:0]          cfg_q [NREG];
   logic [7:0]          cfg_d [NREG];
   logic [NREG-1:0]     cfg_wr_q, cfg_wr_d;
   logic [BufW-1:0]     buf_q, buf_d;
   logic [LenW-1:0]     tx_left_q, tx_left_d;
   logic                tx_start_q, tx_start_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                hist_reset_q, hist_reset_d;
   logic [2:0]          sel_q, sel_d;
   logic                updown_q, updown_d;
   logic                pstep_q, pstep_d;
   logic                scanclk_q, scanclk_d;
   logic                clksw_q, clksw_d;
   logic [2:0]          clksw_cnt_q, clksw_cnt_d;
   logic [HcW-1:0]      hc_q, hc_d;
   logic [2:0]          tg_q, tg_d;
   logic [7:0]          steps_q, steps_d;
   logic                busy_q, busy_d;

   logic [1:0]          err_inc;
   logic [8:0]          err_sum;
   logic [AW-1:0]       ra;
   logic                a_ok;

   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      arg0_d       = arg0_q;
      arg1_d       = arg1_q;
      arg_cnt_d    = arg_cnt_q;
      tmo_d        = tmo_q;
      cfg_d        = cfg_q;
      cfg_wr_d     = '0;
      buf_d        = buf_q;
      tx_left_d    = tx_left_q;
      tx_start_d   = 1'b0;
      tx_data_d    = tx_data_q;
      hist_reset_d = 1'b0;
      sel_d        = sel_q;
      updown_d     = updown_q;
      pstep_d      = pstep_q;
      scanclk_d    = scanclk_q;
      clksw_d      = clksw_q;
      clksw_cnt_d  = clksw_cnt_q;
      hc_d         = hc_q;
      tg_d         = tg_q;
      steps_d      = steps_q;
      err_inc      = 2'd0;
      ra           = arg0_q[AW-1:0];
      a_ok         = (32'(arg0_q) < NREG);

      case (state_q)
         StIdle: begin
            if (uart.rx_ready) begin
               opcode_d  = uart.rx_data;
               arg_cnt_d = 2'd0;
               tmo_d     = '0;
               state_d   = (num_args(uart.rx_data) == 2'd0) ? StExec : StArgs;
            end
         end
         StArgs: begin
            if (uart.rx_ready) begin
               tmo_d = '0;
               if (arg_cnt_q == 2'd0) arg0_d = uart.rx_data;
               else                   arg1_d = uart.rx_data;
               arg_cnt_d = arg_cnt_q + 2'd1;
               if (arg_cnt_q + 2'd1 == num_args(opcode_q)) state_d = StExec;
            end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
               err_inc = err_inc + 2'd1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StExec: begin
            state_d = StIdle;
            case (opcode_q)
               8'h00: begin
                  buf_d       = '0;
                  buf_d[7:0]  = 8'(FW_VERSION);
                  tx_left_d   = LenW'(1);
                  state_d     = StTxLoad;
               end
               8'h01: begin
                  if (a_ok) begin
                     cfg_d[ra]    = arg1_q;
                     cfg_wr_d[ra] = 1'b1;
                  end else begin
                     err_inc = err_inc + 2'd1;
                  end
               end
               8'h02: begin
                  buf_d = '0;
                  if (a_ok) buf_d[7:0] = cfg_q[ra];
                  else      err_inc = err_inc + 2'd1;
                  tx_left_d = LenW'(1);
                  state_d   = StTxLoad;
               end
               8'h03: begin
                  // Snapshot and clear in the same cycle so no counts are lost or doubled.
                  buf_d        = hist;
                  hist_reset_d = 1'b1;
                  tx_left_d    = LenW'(NBytes);
                  state_d      = StTxLoad;
               end
               8'h04: begin
                  clksw_d     = 1'b1;
                  clksw_cnt_d = 3'd0;
                  state_d     = StClksw;
               end
               8'h05: begin
                  sel_d = arg0_q[2:0];
                  if (arg1_q != 8'd0) begin
                     pstep_d   = 1'b1;
                     scanclk_d = 1'b0;
                     hc_d      = '0;
                     tg_d      = 3'd0;
                     steps_d   = arg1_q;
                     state_d   = StPstep;
                  end
               end
               8'h06:   updown_d = ~updown_q;
               default: err_inc = err_inc + 2'd1;
            endcase
         end
         StTxLoad: begin
            if (!uart.tx_busy) begin
               tx_data_d  = buf_q[7:0];
               buf_d      = buf_q >> 8;
               tx_left_d  = tx_left_q - LenW'(1);
               tx_start_d = 1'b1;
               state_d    = StTxWait;
            end
         end
         StTxWait: state_d = (tx_left_q == '0) ? StIdle : StTxLoad;
         StClksw: begin
            if (clksw_cnt_q == 3'd7) begin
               clksw_d = 1'b0;
               state_d = StIdle;
            end else begin
               clksw_cnt_d = clksw_cnt_q + 3'd1;
            end
         end
         StPstep: begin
            if (hc_q == HcW'(SCAN_HALF - 1)) begin
               hc_d      = '0;
               scanclk_d = ~scanclk_q;
               if (tg_q == 3'd5) pstep_d = 1'b0;
               if (tg_q == 3'd7) begin
                  // 8th toggle closes this step and opens the next one on the same edge.
                  tg_d    = 3'd0;
                  steps_d = steps_q - 8'd1;
                  if (steps_q == 8'd1) state_d = StIdle;
                  else                 pstep_d = 1'b1;
               end else begin
                  tg_d = tg_q + 3'd1;
               end
            end else begin
               hc_d = hc_q + HcW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (uart.rx_ready && (state_q inside {StExec, StTxLoad, StTxWait, StClksw, StPstep})) begin
         err_inc = err_inc + 2'd1;
      end

      err_sum = {1'b0, err_q} + {7'd0, err_inc};
      err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         opcode_q     <= '0;
         arg0_q       <= '0;
         arg1_q       <= '0;
         arg_cnt_q    <= '0;
         tmo_q        <= '0;
         err_q        <= '0;
         cfg_q        <= '{default: '0};
         cfg_wr_q     <= '0;
         buf_q        <= '0;
         tx_left_q    <= '0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= '0;
         hist_reset_q <= 1'b0;
         sel_q        <= '0;
         updown_q     <= 1'b1;
         pstep_q      <= 1'b0;
         scanclk_q    <= 1'b0;
         clksw_q      <= 1'b0;
         clksw_cnt_q  <= '0;
         hc_q         <= '0;
         tg_q         <= '0;
         steps_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         opcode_q     <= opcode_d;
         arg0_q       <= arg0_d;
         arg1_q       <= arg1_d;
         arg_cnt_q    <= arg_cnt_d;
         tmo_q        <= tmo_d;
         err_q        <= err_d;
         cfg_q        <= cfg_d;
         cfg_wr_q     <= cfg_wr_d;
         buf_q        <= buf_d;
         tx_left_q    <= tx_left_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         hist_reset_q <= hist_reset_d;
         sel_q        <= sel_d;
         updown_q     <= updown_d;
         pstep_q      <= pstep_d;
         scanclk_q    <= scanclk_d;
         clksw_q      <= clksw_d;
         clksw_cnt_q  <= clksw_cnt_d;
         hc_q         <= hc_d;
         tg_q         <= tg_d;
         steps_q      <= steps_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) cfg[i*8 +: 8] = cfg_q[i];
   end

   assign uart.tx_start = tx_start_q;
   assign uart.tx_data  = tx_data_q;
   assign hist_reset    = hist_reset_q;
   assign cfg_wr        = cfg_wr_q;
   assign phase_cnt_sel = sel_q;
   assign phase_updown  = updown_q;
   assign phase_step    = pstep_q;
   assign scanclk       = scanclk_q;
   assign clkswitch     = clksw_q;
   assign busy          = busy_q;
   assign err_count     = err_q;

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Self-checking bench for serial_cmd_engine: directed protocol cases plus random command traffic
// compared against a byte-level model of the command set.
module tb_serial_cmd_engine;
   localparam int unsigned NCH  = 4;
   localparam int unsigned HW   = 32;
   localparam int unsigned NREG = 8;
   localparam int unsigned FW   = 10;
   localparam int unsigned SH   = 16;
   localparam int unsigned TMO  = 200;

   logic                 clk;
   logic                 rst_n;
   logic [NCH*HW-1:0]    hist;
   logic                 hist_reset;
   logic [NREG*8-1:0]    cfg;
   logic [NREG-1:0]      cfg_wr;
   logic [2:0]           phase_cnt_sel;
   logic                 phase_updown, phase_step, scanclk, clkswitch, busy;
   logic [7:0]           err_count;

   serial_cmd_engine_if u_if ();

   serial_cmd_engine #(
      .NCH(NCH), .HW(HW), .NREG(NREG), .FW_VERSION(FW), .SCAN_HALF(SH), .TIMEOUT(TMO)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .uart(u_if), .hist(hist), .hist_reset(hist_reset),
      .cfg(cfg), .cfg_wr(cfg_wr), .phase_cnt_sel(phase_cnt_sel), .phase_updown(phase_updown),
      .phase_step(phase_step), .scanclk(scanclk), .clkswitch(clkswitch), .busy(busy),
      .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_pass = 0;
   int         n_checks = 0;
   logic [7:0] got_q[$];
   int         hr_cnt = 0;
   int         wr_cnt [NREG];
   int         busy_left = 0;
   int         busy_hold = 0;
   logic [7:0] exp_cfg [NREG];
   int         exp_err;
   logic       exp_updown;
   logic [7:0] exp_q[$];

   // Transmitter/histogrammer stand-in: records bytes and strobes, holds tx_busy after each start.
   assign u_if.tx_busy = (busy_left > 0);
   always @(negedge clk) begin
      if (u_if.tx_start) begin
         got_q.push_back(u_if.tx_data);
         busy_left <= busy_hold;
      end else if (busy_left > 0) begin
         busy_left <= busy_left - 1;
      end
      if (hist_reset) hr_cnt <= hr_cnt + 1;
      for (int i = 0; i < NREG; i++) if (cfg_wr[i]) wr_cnt[i] <= wr_cnt[i] + 1;
   end

   initial begin
      for (int i = 0; i < NREG; i++) wr_cnt[i] = 0;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      u_if.rx_ready = 1'b1;
      u_if.rx_data  = b;
      tick();
      u_if.rx_ready = 1'b0;
   endtask

   function automatic int nargs(input logic [7:0] op);
      if (op == 8'h01 || op == 8'h05) return 2;
      if (op == 8'h02) return 1;
      return 0;
   endfunction

   task automatic err_up();
      if (exp_err < 255) exp_err++;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) exp_cfg[i] = 8'h00;
      exp_err    = 0;
      exp_updown = 1'b1;
   endtask

   // Command semantics at byte level: expected reply bytes and state effects.
   task automatic model_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] v);
      int ai;
      ai = int'(a);
      exp_q.delete();
      case (op)
         8'h00: exp_q.push_back(8'(FW));
         8'h01: if (ai < NREG) exp_cfg[ai] = v; else err_up();
         8'h02: begin
            if (ai < NREG) exp_q.push_back(exp_cfg[ai]);
            else begin
               exp_q.push_back(8'h00);
               err_up();
            end
         end
         8'h03: for (int k = 0; k < NCH*HW/8; k++) exp_q.push_back(hist[8*k +: 8]);
         8'h04, 8'h05: ;
         8'h06: exp_updown = ~exp_updown;
         default: err_up();
      endcase
   endtask

   task automatic check_state(input string tag);
      logic [63:0] e;
      e = '0;
      for (int i = 0; i < NREG; i++) e[i*8 +: 8] = exp_cfg[i];
      check_eq({tag, "_cfg"}, 64'(cfg), e);
      check_eq({tag, "_err"}, 64'(err_count), 64'(exp_err));
      check_eq({tag, "_updown"}, 64'(phase_updown), 64'(exp_updown));
   endtask

   task automatic run_cmd(input string tag, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] v);
      int base, n, na;
      base = got_q.size();
      model_cmd(op, a, v);
      na = nargs(op);
      send_byte(op);
      if (na > 0) begin
         repeat ($urandom_range(0, 3)) tick();
         send_byte(a);
      end
      if (na > 1) begin
         repeat ($urandom_range(0, 3)) tick();
         send_byte(v);
      end
      n = 0;
      while (busy && n < 4000) begin
         tick();
         n++;
      end
      check_eq({tag, "_idle"}, 64'(busy), 64'd0);
      check_eq({tag, "_txcount"}, 64'(got_q.size() - base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
         check_eq({tag, "_txbyte"}, 64'(got_q[base+i]), 64'(exp_q[i]));
      check_state(tag);
   endtask

   initial begin
      int base, hr0, wr0, cnt, bad_sc, bad_ps, bad_busy, togg, n;
      int r;
      logic prev;
      logic [7:0] op;

      u_if.rx_ready = 1'b0;
      u_if.rx_data  = 8'h00;
      hist  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      rst_n = 1'b0;
      model_reset();
      repeat (3) tick();
      check_eq("rst_outs",
               64'({u_if.tx_start, u_if.tx_data, hist_reset, cfg_wr, phase_cnt_sel, phase_step,
                    scanclk, clkswitch, busy, err_count, phase_updown}), 64'd1);
      check_eq("rst_cfg", 64'(cfg), 64'd0);
      rst_n = 1'b1;
      tick();

      // Firmware version: tx_start on the second edge after the opcode is sampled.
      base = got_q.size();
      send_byte(8'h00);
      check_eq("fw_start_e1", 64'(u_if.tx_start), 64'd0);
      tick();
      check_eq("fw_start_e2", 64'(u_if.tx_start), 64'd0);
      tick();
      check_eq("fw_start_e3", 64'(u_if.tx_start), 64'd1);
      check_eq("fw_data", 64'(u_if.tx_data), 64'h0A);
      tick();
      check_eq("fw_start_e4", 64'(u_if.tx_start), 64'd0);
      repeat (2) tick();
      check_eq("fw_busy_low", 64'(busy), 64'd0);
      check_eq("fw_once", 64'(got_q.size() - base), 64'd1);
      check_eq("fw_err", 64'(err_count), 64'd0);

      // Config write with cycle-accurate strobe, then readback and an out-of-range write.
      wr0 = wr_cnt[3];
      model_cmd(8'h01, 8'h03, 8'hA5);
      send_byte(8'h01);
      send_byte(8'h03);
      send_byte(8'hA5);
      check_eq("wr_strobe_e1", 64'(cfg_wr), 64'd0);
      tick();
      check_eq("wr_strobe_e2", 64'(cfg_wr), 64'h08);
      check_eq("wr_value", 64'(cfg[31:24]), 64'hA5);
      tick();
      check_eq("wr_strobe_e3", 64'(cfg_wr), 64'd0);
      check_eq("wr_pulse_len", 64'(wr_cnt[3] - wr0), 64'd1);
      run_cmd("rd3", 8'h02, 8'h03, 8'h00);
      run_cmd("wr_bad", 8'h01, 8'h09, 8'h11);

      // Histogram snapshot under a slow transmitter, live counters changing mid-reply.
      busy_hold = 5;
      base = got_q.size();
      hr0  = hr_cnt;
      fork
         run_cmd("hist", 8'h03, 8'h00, 8'h00);
         begin
            for (int k = 0; k < 200 && got_q.size() <= base; k++) tick();
            hist = {$urandom, $urandom, $urandom, $urandom};
         end
      join
      check_eq("hist_reset_once", 64'(hr_cnt - hr0), 64'd1);
      busy_hold = 0;

      // clkswitch pulse width; a byte arriving meanwhile is dropped and counted.
      base = got_q.size();
      model_cmd(8'h04, 8'h00, 8'h00);
      send_byte(8'h04);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         u_if.rx_ready = (i == 3);
         u_if.rx_data  = 8'h00;
         if (clkswitch) cnt++;
         tick();
      end
      u_if.rx_ready = 1'b0;
      err_up();
      check_eq("clksw_cycles", 64'(cnt), 64'd8);
      check_eq("clksw_idle", 64'(busy), 64'd0);
      check_eq("clksw_dropped_tx", 64'(got_q.size() - base), 64'd0);
      check_state("clksw");

      // Two PLL phase steps on counter 3, compared against the ideal scanclk/phasestep waveform.
      send_byte(8'h05);
      send_byte(8'h03);
      send_byte(8'h02);
      tick();
      check_eq("ps_sel", 64'(phase_cnt_sel), 64'd3);
      bad_sc = 0; bad_ps = 0; bad_busy = 0; togg = 0; prev = 1'b0;
      for (int t = 0; t < 256; t++) begin
         if (scanclk !== 1'(((t % 128) / SH) % 2)) bad_sc++;
         if (phase_step !== ((t % 128) < 6 * SH)) bad_ps++;
         if (busy !== 1'b1) bad_busy++;
         if (scanclk !== prev) togg++;
         prev = scanclk;
         tick();
      end
      if (scanclk !== prev) togg++;
      check_eq("ps_scanclk_wave", 64'(bad_sc), 64'd0);
      check_eq("ps_step_wave", 64'(bad_ps), 64'd0);
      check_eq("ps_busy_during", 64'(bad_busy), 64'd0);
      check_eq("ps_toggles", 64'(togg), 64'd16);
      check_eq("ps_end", 64'({busy, phase_step, scanclk}), 64'd0);
      check_state("ps");

      // Argument timeout: still waiting just before the limit, aborted just after.
      send_byte(8'h01);
      send_byte(8'h02);
      repeat (TMO - 10) tick();
      check_eq("tmo_waiting", 64'(busy), 64'd1);
      repeat (20) tick();
      err_up();
      check_eq("tmo_abort", 64'(busy), 64'd0);
      check_state("tmo");
      run_cmd("tmo_after", 8'h00, 8'h00, 8'h00);

      // Random traffic against the model.
      for (int i = 0; i < 60; i++) begin
         busy_hold = $urandom_range(0, 4);
         r = $urandom_range(0, 4);
         case (r)
            0:       op = 8'h00;
            1:       op = 8'h01;
            2:       op = 8'h02;
            3:       op = 8'h06;
            default: op = 8'($urandom_range(7, 255));
         endcase
         run_cmd("rand", op, 8'($urandom_range(0, 11)), 8'($urandom));
      end
      busy_hold = 0;

      // Reset in the middle of a phase step while scanclk is high.
      if (exp_updown) run_cmd("ud", 8'h06, 8'h00, 8'h00);
      send_byte(8'h05);
      send_byte(8'h01);
      send_byte(8'h05);
      n = 0;
      while (scanclk !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check_eq("rst_mid_scan_high", 64'(scanclk), 64'd1);
      rst_n = 1'b0;
      tick();
      check_eq("rst_mid_outs", 64'({scanclk, phase_step, phase_updown, busy}), 64'b0010);
      check_eq("rst_mid_cfg_err", 64'({cfg, err_count}), 64'd0);
      rst_n = 1'b1;
      model_reset();
      tick();
      run_cmd("post_rst", 8'h00, 8'h00, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
